multicycle_control_unit: RTL and testbench

FSM-sequenced successor to the single-cycle decoder: decodes the RV32I+LBR opcode set and steps each instruction through FETCH/DECODE/EXEC/MEM/LBR/WB with handshakes to instruction memory, data memory and the LBR unit. Sits between the fetch stage and the datapath of the multi-cycle core. Adds a memory-timeout watchdog, illegal-opcode trap and a per-instruction cycle counter.

---
 rtl/multicycle_control_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle sequencer for the RV32I+LBR core. Latches the opcode in
//   FETCH and steps each instruction through FETCH/DECODE/EXEC/MEM/LBR/WB.
//   Illegal opcodes and memory/LBR timeouts park the FSM in TRAP until reset.
//
//   Handshakes: instr_valid, mem_ready and lbr_ready are single-cycle
//   completion strobes. A request (memRead/memWrite/lbrReq) stays high until
//   its ready is sampled high. The FSM leaves MEM/LBR on the same edge.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   opcode[6:0]         instruction[6:0], captured when ir_write=1
//   instr_valid         instruction memory presents a valid instruction
//   mem_ready           data memory finished the access this cycle
//   lbr_ready           LBR unit finished the request this cycle
//   report              enables the per-cycle report strobe in the window
//   ir_write, pc_write  IR latch enable, PC update strobe at retire
//   branch_op, memRead, memWrite, regWrite   control strobes
//   lbrReq[1:0]         10 = read LBR, 11 = write LBR, 00 = idle
//   memtoReg, operand_A_sel, extend_sel, next_PC_sel [1:0]  datapath selects
//   ALUOp[2:0]          ALU operation class
//   operand_B_sel       0 = rs2, 1 = immediate
//   trap                sticky illegal-opcode / timeout flag
//   state[2:0]          FSM state (debug view)
//   report_fire         report=1 and cycle count inside the print window
//   report_cycle[31:0]  free-running cycle counter (wraps at 2^32)
//   report_core[31:0]   core index tag for the report consumer
module multicycle_control_unit #(
  parameter int CORE             = 0,
  parameter int PRINT_CYCLES_MIN = 1,
  parameter int PRINT_CYCLES_MAX = 1000,
  parameter int LBR_ENABLE       = 1,
  parameter int MEM_TIMEOUT      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        lbr_ready,
  input  logic        report,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch_op,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic [1:0]  lbrReq,
  output logic [1:0]  memtoReg,
  output logic [1:0]  operand_A_sel,
  output logic [1:0]  extend_sel,
  output logic [1:0]  next_PC_sel,
  output logic [2:0]  ALUOp,
  output logic        operand_B_sel,
  output logic        trap,
  output logic [2:0]  state,
  output logic        report_fire,
  output logic [31:0] report_cycle,
  output logic [31:0] report_core
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_RDLBR  = 7'b0001011;
  localparam logic [6:0] OP_WRLBR  = 7'b0101011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_LBR    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      opcode_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [31:0]     cycle_q;

  logic is_load, is_store, is_branch, is_rdlbr, is_wrlbr, is_lbr;
  logic is_wb_class, is_retire_exec, legal;

  always_comb begin
    is_load        = (opcode_q == OP_LOAD);
    is_store       = (opcode_q == OP_STORE);
    is_branch      = (opcode_q == OP_BRANCH);
    is_rdlbr       = (opcode_q == OP_RDLBR);
    is_wrlbr       = (opcode_q == OP_WRLBR);
    is_lbr         = is_rdlbr | is_wrlbr;
    is_wb_class    = (opcode_q == OP_R)    | (opcode_q == OP_I)   |
                     (opcode_q == OP_JAL)  | (opcode_q == OP_JALR) |
                     (opcode_q == OP_AUIPC)| (opcode_q == OP_LUI);
    is_retire_exec = is_branch | (opcode_q == OP_FENCE) | (opcode_q == OP_SYSTEM);
    legal          = is_load | is_store | is_wb_class | is_retire_exec |
                     (is_lbr && (LBR_ENABLE != 0));
  end

  // State register, opcode latch, MEM/LBR watchdog and cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= 7'd0;
      tmo_q    <= '0;
      cycle_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      cycle_q  <= cycle_q + 32'd1;
      if (ir_write) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch_op     = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    regWrite      = 1'b0;
    lbrReq        = 2'b00;
    memtoReg      = 2'b00;
    operand_A_sel = 2'b00;
    extend_sel    = 2'b00;
    next_PC_sel   = 2'b00;
    ALUOp         = 3'b000;
    operand_B_sel = 1'b0;
    trap          = 1'b0;

    // Datapath selects are only meaningful once the instruction is executing.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_LBR || state_q == S_WB) begin
      case (opcode_q)
        OP_R:      ALUOp = 3'b000;
        OP_I:      begin ALUOp = 3'b001; operand_B_sel = 1'b1; end
        OP_BRANCH: begin ALUOp = 3'b010; next_PC_sel = 2'b01; end
        OP_JAL:    begin ALUOp = 3'b011; operand_A_sel = 2'b10; next_PC_sel = 2'b10; end
        OP_JALR:   begin ALUOp = 3'b011; operand_A_sel = 2'b10; next_PC_sel = 2'b11; end
        OP_RDLBR:  begin ALUOp = 3'b011; memtoReg = 2'b10; end
        OP_WRLBR:  ALUOp = 3'b011;
        OP_LOAD:   begin ALUOp = 3'b100; operand_B_sel = 1'b1; memtoReg = 2'b01; end
        OP_STORE:  begin ALUOp = 3'b101; operand_B_sel = 1'b1; extend_sel = 2'b01; end
        OP_AUIPC:  begin ALUOp = 3'b110; operand_A_sel = 2'b01; operand_B_sel = 1'b1;
                         extend_sel = 2'b10; end
        OP_LUI:    begin ALUOp = 3'b110; operand_A_sel = 2'b11; operand_B_sel = 1'b1;
                         extend_sel = 2'b10; end
        default:   ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ir_write = instr_valid;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        branch_op = is_branch;
        tmo_d     = '0;
        if (is_load || is_store) state_d = S_MEM;
        else if (is_lbr)         state_d = S_LBR;
        else if (is_wb_class)    state_d = S_WB;
        else begin
          state_d  = S_FETCH;
          pc_write = 1'b1;
        end
      end
      S_MEM: begin
        memRead  = is_load;
        memWrite = is_store;
        // Ready on the cycle the watchdog would expire still completes.
        if (mem_ready) begin
          if (is_load) state_d = S_WB;
          else begin
            state_d  = S_FETCH;
            pc_write = 1'b1;
          end
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) state_d = S_TRAP;
        else tmo_d = tmo_q + TW'(1);
      end
      S_LBR: begin
        lbrReq = is_rdlbr ? 2'b10 : 2'b11;
        if (lbr_ready) begin
          if (is_rdlbr) state_d = S_WB;
          else begin
            state_d  = S_FETCH;
            pc_write = 1'b1;
          end
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) state_d = S_TRAP;
        else tmo_d = tmo_q + TW'(1);
      end
      S_WB: begin
        regWrite = 1'b1;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  assign state        = state_q;
  assign report_cycle = cycle_q;
  assign report_core  = 32'(CORE);
  assign report_fire  = report && (cycle_q >= 32'(PRINT_CYCLES_MIN)) &&
                        (cycle_q <= 32'(PRINT_CYCLES_MAX));

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        instr_valid, mem_ready, lbr_ready, report;

  logic        ir_write, pc_write, branch_op, memRead, memWrite, regWrite;
  logic [1:0]  lbrReq, memtoReg, operand_A_sel, extend_sel, next_PC_sel;
  logic [2:0]  ALUOp, state;
  logic        operand_B_sel, trap, report_fire;
  logic [31:0] report_cycle, report_core;

  logic        ir_write2, pc_write2, branch_op2, memRead2, memWrite2, regWrite2;
  logic [1:0]  lbrReq2, memtoReg2, operand_A_sel2, extend_sel2, next_PC_sel2;
  logic [2:0]  ALUOp2, state2;
  logic        operand_B_sel2, trap2, report_fire2;
  logic [31:0] report_cycle2, report_core2;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  multicycle_control_unit #(.CORE(0), .LBR_ENABLE(1), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .lbr_ready(lbr_ready), .report(report),
    .ir_write(ir_write), .pc_write(pc_write), .branch_op(branch_op),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .lbrReq(lbrReq),
    .memtoReg(memtoReg), .operand_A_sel(operand_A_sel), .extend_sel(extend_sel),
    .next_PC_sel(next_PC_sel), .ALUOp(ALUOp), .operand_B_sel(operand_B_sel),
    .trap(trap), .state(state), .report_fire(report_fire),
    .report_cycle(report_cycle), .report_core(report_core)
  );

  // Same stimulus, LBR opcodes disabled.
  multicycle_control_unit #(.CORE(1), .LBR_ENABLE(0)) dut_nolbr (
    .clock(clock), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .lbr_ready(lbr_ready), .report(report),
    .ir_write(ir_write2), .pc_write(pc_write2), .branch_op(branch_op2),
    .memRead(memRead2), .memWrite(memWrite2), .regWrite(regWrite2), .lbrReq(lbrReq2),
    .memtoReg(memtoReg2), .operand_A_sel(operand_A_sel2), .extend_sel(extend_sel2),
    .next_PC_sel(next_PC_sel2), .ALUOp(ALUOp2), .operand_B_sel(operand_B_sel2),
    .trap(trap2), .state(state2), .report_fire(report_fire2),
    .report_cycle(report_cycle2), .report_core(report_core2)
  );

  logic [23:0] all_out;
  assign all_out = {ir_write, pc_write, branch_op, memRead, memWrite, regWrite, lbrReq,
                    memtoReg, operand_A_sel, extend_sel, next_PC_sel, ALUOp,
                    operand_B_sel, trap, state};

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Fetch op, pass DECODE, return with the FSM in EXEC.
  task automatic run_to_exec(input logic [6:0] op);
    opcode      = op;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    opcode      = 7'd0;
    tick();
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] nxt;
    logic       br, pcw;
    logic [2:0] alu;
    logic [1:0] asel;
    logic       bsel;
    logic [1:0] ext, npc, mtr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{7'b0110011, 3'd5, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0}; // R
    vecs[1]  = '{7'b0010011, 3'd5, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0}; // I
    vecs[2]  = '{7'b0100011, 3'd3, 1'b0, 1'b0, 3'd5, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0}; // STORE
    vecs[3]  = '{7'b0000011, 3'd3, 1'b0, 1'b0, 3'd4, 2'd0, 1'b1, 2'd0, 2'd0, 2'd1}; // LOAD
    vecs[4]  = '{7'b1100011, 3'd0, 1'b1, 1'b1, 3'd2, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0}; // BRANCH
    vecs[5]  = '{7'b1100111, 3'd5, 1'b0, 1'b0, 3'd3, 2'd2, 1'b0, 2'd0, 2'd3, 2'd0}; // JALR
    vecs[6]  = '{7'b1101111, 3'd5, 1'b0, 1'b0, 3'd3, 2'd2, 1'b0, 2'd0, 2'd2, 2'd0}; // JAL
    vecs[7]  = '{7'b0010111, 3'd5, 1'b0, 1'b0, 3'd6, 2'd1, 1'b1, 2'd2, 2'd0, 2'd0}; // AUIPC
    vecs[8]  = '{7'b0110111, 3'd5, 1'b0, 1'b0, 3'd6, 2'd3, 1'b1, 2'd2, 2'd0, 2'd0}; // LUI
    vecs[9]  = '{7'b0001011, 3'd4, 1'b0, 1'b0, 3'd3, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2}; // RDLBR
    vecs[10] = '{7'b0001111, 3'd0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0}; // FENCE
    vecs[11] = '{7'b1110011, 3'd0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0}; // SYSTEM
  end

  // ---------------- stimulus ----------------
  initial begin
    int rd_cycles;
    reset = 1'b1; opcode = 7'd0; instr_valid = 1'b0;
    mem_ready = 1'b0; lbr_ready = 1'b0; report = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'(all_out), 32'd0);
    check("reset_cycle", report_cycle, 32'd0);
    check("reset_trap2", {31'd0, trap2}, 32'd0);
    reset  = 1'b0;
    report = 1'b1;
    #1;
    check("report_below_min", {31'd0, report_fire}, 32'd0);
    tick();
    check("cycle_after_one", report_cycle, 32'd1);
    check("report_at_min", {31'd0, report_fire}, 32'd1);
    report = 1'b0;
    #1;
    check("report_off", {31'd0, report_fire}, 32'd0);

    // R-type full walk: 0,1,2,5,0
    opcode = 7'b0110011; instr_valid = 1'b1; #1;
    check("r_fetch_irw", {29'd0, ir_write, state}, {29'd0, 1'b1, 3'd0});
    tick();
    instr_valid = 1'b0; opcode = 7'd0; #1;
    check("r_decode", 32'(all_out), {8'd0, 21'd0, 3'd1});
    tick();
    check("r_exec", {28'd0, pc_write, regWrite, state[1:0]}, {28'd0, 1'b0, 1'b0, 2'd2});
    check("r_exec_alu", {29'd0, ALUOp}, 32'd0);
    tick();
    check("r_wb", {27'd0, pc_write, regWrite, state}, {27'd0, 1'b1, 1'b1, 3'd5});
    tick();
    check("r_back_fetch", 32'(all_out), 32'd0);

    // Decode table, checked in EXEC, then next state.
    for (int i = 0; i < 12; i++) begin
      run_to_exec(vecs[i].op);
      check($sformatf("tbl%0d_state", i), {29'd0, state}, 32'd2);
      check($sformatf("tbl%0d_sel", i),
            {20'd0, ALUOp, operand_A_sel, operand_B_sel, extend_sel, next_PC_sel, memtoReg},
            {20'd0, vecs[i].alu, vecs[i].asel, vecs[i].bsel, vecs[i].ext, vecs[i].npc, vecs[i].mtr});
      check($sformatf("tbl%0d_strobe", i),
            {25'd0, branch_op, pc_write, regWrite, memRead, memWrite, lbrReq},
            {25'd0, vecs[i].br, vecs[i].pcw, 5'd0});
      tick();
      check($sformatf("tbl%0d_next", i), {29'd0, state}, {29'd0, vecs[i].nxt});
      do_reset();
    end

    // LOAD with 3 wait cycles.
    run_to_exec(7'b0000011);
    tick();
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      if (memRead && state == 3'd3) rd_cycles++;
      tick();
    end
    mem_ready = 1'b0; #1;
    check("load_memread_cycles", 32'(rd_cycles), 32'd4);
    check("load_wb", {26'd0, memtoReg, regWrite, memRead, state[1:0]},
          {26'd0, 2'b01, 1'b1, 1'b0, 2'd1});
    tick();
    check("load_fetch", {29'd0, state}, 32'd0);

    // STORE with ready arriving on the last allowed cycle: completes.
    run_to_exec(7'b0100011);
    tick();
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 1'b1; #1;
    check("store_late_ready", {28'd0, memWrite, pc_write, trap, state == 3'd3},
          {28'd0, 4'b1101});
    tick();
    mem_ready = 1'b0; #1;
    check("store_late_done", {29'd0, state}, 32'd0);

    // STORE timeout -> TRAP, sticky until reset.
    run_to_exec(7'b0100011);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("store_wait%0d", i), {30'd0, memWrite, state == 3'd3}, 32'd3);
      tick();
    end
    check("timeout_trap", 32'(all_out), {22'd0, 1'b1, 1'b0} << 0 | 32'h0000_0000 | {29'd0, 3'd6} | 32'd8);
    instr_valid = 1'b1; mem_ready = 1'b1; lbr_ready = 1'b1;
    tick(); tick();
    check("trap_sticky", {28'd0, trap, state}, {28'd0, 1'b1, 3'd6});
    instr_valid = 1'b0; mem_ready = 1'b0; lbr_ready = 1'b0;
    do_reset();
    check("trap_cleared", {28'd0, trap, state}, 32'd0);

    // RDLBR with lbr_ready after 1 cycle; LBR_ENABLE=0 instance traps.
    run_to_exec(7'b0001011);
    check("nolbr_trap", {28'd0, trap2, state2}, {28'd0, 1'b1, 3'd6});
    tick();
    check("rdlbr_req0", {27'd0, lbrReq, state}, {27'd0, 2'b10, 3'd4});
    tick();
    lbr_ready = 1'b1; #1;
    check("rdlbr_req1", {27'd0, lbrReq, state}, {27'd0, 2'b10, 3'd4});
    tick();
    lbr_ready = 1'b0; #1;
    check("rdlbr_wb", {25'd0, memtoReg, regWrite, lbrReq, state[0]},
          {25'd0, 2'b10, 1'b1, 2'b00, 1'b1});
    tick();
    check("rdlbr_fetch", {29'd0, state}, 32'd0);
    do_reset();

    // WRLBR immediate ready.
    run_to_exec(7'b0101011);
    tick();
    lbr_ready = 1'b1; #1;
    check("wrlbr_req", {27'd0, lbrReq, pc_write, regWrite, trap}, {27'd0, 2'b11, 3'b100});
    tick();
    lbr_ready = 1'b0; #1;
    check("wrlbr_fetch", 32'(all_out), 32'd0);

    // Illegal opcode traps from DECODE.
    run_to_exec(7'b1111111);
    check("illegal_trap", {28'd0, trap, state}, {28'd0, 1'b1, 3'd6});
    do_reset();

    // Reset in the middle of MEM.
    run_to_exec(7'b0000011);
    tick();
    check("mid_mem_read", {31'd0, memRead}, 32'd1);
    do_reset();
    check("mid_mem_reset", 32'(all_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
